// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: load/store unit sitting behind the EX/MEM register.
// Issues data-memory requests and aligns write lanes on stores.
// Selects and extends read lanes on loads, and fills the MEM/WB register.
// The upstream pipeline is held while an access is in flight.
module mem_stage_lsu #(
  parameter int DM_ADDR_W     = 9,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_RegWrite,
  input  logic                 in_MemtoReg,
  input  logic                 in_MemRead,
  input  logic                 in_MemWrite,
  input  logic [31:0]          in_Alu_Result,
  input  logic [31:0]          in_RD_Two,
  input  logic [4:0]           in_rd,
  input  logic [2:0]           in_func3,
  input  logic [31:0]          in_Curr_Instr,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DM_ADDR_W-1:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata,
  output logic                 wb_valid,
  output logic                 wb_RegWrite,
  output logic                 wb_MemtoReg,
  output logic [31:0]          wb_Alu_Result,
  output logic [31:0]          wb_MemReadData,
  output logic [4:0]           wb_rd,
  output logic [31:0]          wb_Curr_Instr,
  output logic                 misalign_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [DM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]             mem_be_q, mem_be_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic                   h_regwrite_q, h_regwrite_d;
  logic                   h_memtoreg_q, h_memtoreg_d;
  logic                   h_memwrite_q, h_memwrite_d;
  logic [31:0]            h_alu_q, h_alu_d;
  logic [4:0]             h_rd_q, h_rd_d;
  logic [2:0]             h_func3_q, h_func3_d;
  logic [31:0]            h_instr_q, h_instr_d;
  logic                   wb_valid_q, wb_valid_d;
  logic                   wb_regwrite_q, wb_regwrite_d;
  logic                   wb_memtoreg_q, wb_memtoreg_d;
  logic [31:0]            wb_alu_q, wb_alu_d;
  logic [31:0]            wb_rdata_q, wb_rdata_d;
  logic [4:0]             wb_rd_q, wb_rd_d;
  logic [31:0]            wb_instr_q, wb_instr_d;
  logic                   is_mem, illegal, stall_c, misalign_c;
  logic [3:0]             be_c;
  logic [31:0]            wdata_c, load_data;
  logic [7:0]             lane_byte;
  logic [15:0]            lane_half;

  assign is_mem = in_MemRead | in_MemWrite;

  // Flag accesses whose size and address cannot be served as one aligned word access
  always_comb begin
    illegal = 1'b0;
    if (MISALIGN_TRAP) begin
      case (in_func3)
        3'b001, 3'b101:         illegal = in_Alu_Result[0];
        3'b010:                 illegal = |in_Alu_Result[1:0];
        3'b011, 3'b110, 3'b111: illegal = 1'b1;
        default:                illegal = 1'b0;
      endcase
    end
  end

  // Byte enables and lane-replicated write data for the incoming access size
  always_comb begin
    case (in_func3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << in_Alu_Result[1:0];
        wdata_c = {4{in_RD_Two[7:0]}};
      end
      2'b01: begin
        be_c    = in_Alu_Result[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{in_RD_Two[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = in_RD_Two;
      end
    endcase
  end

  // Pick the addressed byte/half from the read word and sign- or zero-extend it
  always_comb begin
    case (h_alu_q[1:0])
      2'b00:   lane_byte = mem_rdata[7:0];
      2'b01:   lane_byte = mem_rdata[15:8];
      2'b10:   lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = h_alu_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (h_func3_q)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_data = {24'h0, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_data = {16'h0, lane_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Access sequencer: next state, request outputs, holding registers and MEM/WB fields
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    h_regwrite_d  = h_regwrite_q;
    h_memtoreg_d  = h_memtoreg_q;
    h_memwrite_d  = h_memwrite_q;
    h_alu_d       = h_alu_q;
    h_rd_d        = h_rd_q;
    h_func3_d     = h_func3_q;
    h_instr_d     = h_instr_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_memtoreg_d = wb_memtoreg_q;
    wb_alu_d      = wb_alu_q;
    wb_rdata_d    = wb_rdata_q;
    wb_rd_d       = wb_rd_q;
    wb_instr_d    = wb_instr_q;
    stall_c       = 1'b0;
    misalign_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && is_mem && !illegal) begin
          stall_c      = 1'b1;
          state_d      = S_REQ;
          mem_req_d    = 1'b1;
          mem_we_d     = in_MemWrite;
          mem_addr_d   = in_Alu_Result[DM_ADDR_W+1:2];
          mem_be_d     = be_c;
          mem_wdata_d  = wdata_c;
          h_regwrite_d = in_RegWrite;
          h_memtoreg_d = in_MemtoReg;
          h_memwrite_d = in_MemWrite;
          h_alu_d      = in_Alu_Result;
          h_rd_d       = in_rd;
          h_func3_d    = in_func3;
          h_instr_d    = in_Curr_Instr;
        end else begin
          misalign_c    = in_valid & is_mem & illegal;
          wb_valid_d    = in_valid;
          wb_regwrite_d = in_valid & in_RegWrite & ~(is_mem & illegal);
          wb_memtoreg_d = in_MemtoReg;
          wb_alu_d      = in_Alu_Result;
          wb_rdata_d    = 32'h0;
          wb_rd_d       = in_rd;
          wb_instr_d    = in_Curr_Instr;
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_c = ~mem_rvalid;
        if (mem_rvalid) begin
          state_d       = S_IDLE;
          wb_valid_d    = 1'b1;
          wb_regwrite_d = h_regwrite_q;
          wb_memtoreg_d = h_memtoreg_q;
          wb_alu_d      = h_alu_q;
          wb_rdata_d    = h_memwrite_q ? 32'h0 : load_data;
          wb_rd_d       = h_rd_q;
          wb_instr_d    = h_instr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register everything; reset returns to idle and drops any outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= 4'h0;
      mem_wdata_q   <= 32'h0;
      h_regwrite_q  <= 1'b0;
      h_memtoreg_q  <= 1'b0;
      h_memwrite_q  <= 1'b0;
      h_alu_q       <= 32'h0;
      h_rd_q        <= 5'h0;
      h_func3_q     <= 3'h0;
      h_instr_q     <= 32'h0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_alu_q      <= 32'h0;
      wb_rdata_q    <= 32'h0;
      wb_rd_q       <= 5'h0;
      wb_instr_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      h_regwrite_q  <= h_regwrite_d;
      h_memtoreg_q  <= h_memtoreg_d;
      h_memwrite_q  <= h_memwrite_d;
      h_alu_q       <= h_alu_d;
      h_rd_q        <= h_rd_d;
      h_func3_q     <= h_func3_d;
      h_instr_q     <= h_instr_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      wb_alu_q      <= wb_alu_d;
      wb_rdata_q    <= wb_rdata_d;
      wb_rd_q       <= wb_rd_d;
      wb_instr_q    <= wb_instr_d;
    end
  end

  assign stall          = reset ? 1'b0 : stall_c;
  assign misalign_err   = reset ? 1'b0 : misalign_c;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_be         = mem_be_q;
  assign mem_wdata      = mem_wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_RegWrite    = wb_regwrite_q;
  assign wb_MemtoReg    = wb_memtoreg_q;
  assign wb_Alu_Result  = wb_alu_q;
  assign wb_MemReadData = wb_rdata_q;
  assign wb_rd          = wb_rd_q;
  assign wb_Curr_Instr  = wb_instr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: drives the load/store unit with directed and random
// instructions and compares against a behavioural model of the MEM stage.
module tb_mem_stage_lsu;

  localparam int AW = 9;

  logic          clk, reset;
  logic          in_valid, in_RegWrite, in_MemtoReg, in_MemRead, in_MemWrite;
  logic [31:0]   in_Alu_Result, in_RD_Two, in_Curr_Instr;
  logic [4:0]    in_rd;
  logic [2:0]    in_func3;
  logic          stall, mem_req, mem_we, mem_gnt, mem_rvalid, misalign_err;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          wb_valid, wb_RegWrite, wb_MemtoReg;
  logic [31:0]   wb_Alu_Result, wb_MemReadData, wb_Curr_Instr;
  logic [4:0]    wb_rd;

  int checks = 0;
  int passes = 0;

  int            obs_stall_cycles;
  logic          obs_req_seen, obs_unstable, obs_bubble_bad, obs_misalign;
  logic          obs_we;
  logic [AW-1:0] obs_addr;
  logic [3:0]    obs_be;
  logic [31:0]   obs_wdata;
  logic [103:0]  wb_obs;

  assign wb_obs = {wb_valid, wb_RegWrite, wb_MemtoReg, wb_rd, wb_Alu_Result, wb_MemReadData, wb_Curr_Instr};

  mem_stage_lsu #(.DM_ADDR_W(AW), .MISALIGN_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_RegWrite(in_RegWrite),
    .in_MemtoReg(in_MemtoReg), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
    .in_Alu_Result(in_Alu_Result), .in_RD_Two(in_RD_Two), .in_rd(in_rd),
    .in_func3(in_func3), .in_Curr_Instr(in_Curr_Instr), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
    .wb_MemtoReg(wb_MemtoReg), .wb_Alu_Result(wb_Alu_Result),
    .wb_MemReadData(wb_MemReadData), .wb_rd(wb_rd), .wb_Curr_Instr(wb_Curr_Instr),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: access legality by size and address
  function automatic logic exp_legal(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return (a % 2) == 0;
      3'b010:         return (a % 4) == 0;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    sz = f3 % 4;
    if (sz == 0) return 4'(1 << (a % 4));
    if (sz == 1) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    int unsigned sz;
    sz = f3 % 4;
    if (sz == 0) return (d % 256) * 32'h0101_0101;
    if (sz == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    int unsigned k, v;
    k = a % 4;
    case (f3)
      3'b000, 3'b100: begin
        v = (r >> (8 * k)) & 32'hFF;
        if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (r >> (16 * (k / 2))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = r;
    endcase
    return v;
  endfunction

  function automatic logic [103:0] exp_wb(input logic mr, mw, rw, m2r, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [4:0] rd,
                                          input logic [31:0] instr, rdata);
    if (!(mr || mw)) return {1'b1, rw, m2r, rd, a, 32'h0, instr};
    if (!exp_legal(f3, a)) return {1'b1, 1'b0, m2r, rd, a, 32'h0, instr};
    return {1'b1, rw, m2r, rd, a, (mw ? 32'h0 : exp_load(f3, a, rdata)), instr};
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_MemRead = 1'b0; in_MemWrite = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Present one instruction for one cycle and serve the memory handshake.
  // Entered and left at 1 time unit after a rising edge.
  task automatic run_op(input logic mr, mw, rw, m2r, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd, input logic [31:0] instr,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
    int phase, wcnt;
    logic s0, done;
    obs_stall_cycles = 0; obs_req_seen = 1'b0; obs_unstable = 1'b0; obs_bubble_bad = 1'b0;
    in_valid = 1'b1; in_MemRead = mr; in_MemWrite = mw; in_RegWrite = rw; in_MemtoReg = m2r;
    in_func3 = f3; in_Alu_Result = addr; in_RD_Two = data; in_rd = rd; in_Curr_Instr = instr;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    obs_misalign = misalign_err;
    s0 = stall;
    if (stall) obs_stall_cycles++;
    @(posedge clk); #1;
    in_valid = 1'b0; in_MemRead = 1'b0; in_MemWrite = 1'b0;
    if (!s0) begin
      obs_req_seen = mem_req;
    end else begin
      phase = 0; wcnt = 0; done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
        if (phase == 0) begin
          if (mem_req) begin
            if (!obs_req_seen) begin
              obs_req_seen = 1'b1;
              obs_we = mem_we; obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
            end else if ({mem_we, mem_addr, mem_be, mem_wdata} !== {obs_we, obs_addr, obs_be, obs_wdata}) begin
              obs_unstable = 1'b1;
            end
          end
          mem_gnt = mem_req && (wcnt >= gnt_dly);
          wcnt++;
          @(negedge clk);
          if (stall) obs_stall_cycles++;
          if (wb_valid) obs_bubble_bad = 1'b1;
          if (mem_gnt) begin phase = 1; wcnt = 0; end
        end else begin
          mem_gnt = 1'b0;
          mem_rvalid = (wcnt >= rv_dly);
          mem_rdata = mem_rvalid ? rdata : $urandom;
          wcnt++;
          @(negedge clk);
          if (stall) obs_stall_cycles++;
          if (wb_valid) obs_bubble_bad = 1'b1;
          if (mem_rvalid) done = 1'b1;
        end
        @(posedge clk); #1;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!done) begin
        checks++;
        $display("[TB] FAIL handshake_timeout: access at addr %h never completed within 64 cycles", addr);
        do_reset();
      end
    end
  endtask

  task automatic test_reset();
    logic [200:0] outs;
    do_reset();
    outs = {stall, mem_req, mem_we, misalign_err, wb_valid, wb_RegWrite, wb_MemtoReg, mem_be,
            mem_addr, mem_wdata, wb_Alu_Result, wb_MemReadData, wb_rd, wb_Curr_Instr};
    checks++;
    if (outs !== '0) $display("[TB] FAIL reset_outputs: got %h want 0", outs);
    else passes++;
  endtask

  task automatic test_alu_op();
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 32'h0050_0293, 0, 0, 32'h0);
    checks++;
    if (wb_Alu_Result !== 32'h1234) $display("[TB] FAIL alu_result: got %h want 00001234", wb_Alu_Result);
    else passes++;
    checks++;
    if (wb_rd !== 5'd5) $display("[TB] FAIL alu_rd: got %0d want 5", wb_rd);
    else passes++;
    checks++;
    if ({wb_valid, wb_RegWrite} !== 2'b11) $display("[TB] FAIL alu_ctrl: got %b want 11", {wb_valid, wb_RegWrite});
    else passes++;
    checks++;
    if (obs_stall_cycles != 0) $display("[TB] FAIL alu_stall: got %0d stall cycles want 0", obs_stall_cycles);
    else passes++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s[3]   = '{3'b000, 3'b101, 3'b001};
    logic [31:0] addrs[3] = '{32'h103, 32'h102, 32'h102};
    logic [31:0] rds[3]   = '{32'h80FF_FF7F, 32'hBEEF_0000, 32'hBEEF_0000};
    logic [31:0] wants[3] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_BEEF};
    logic [3:0]  bes[3]   = '{4'b1000, 4'b1100, 4'b1100};
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, 1'b0, 1'b1, 1'b1, f3s[i], addrs[i], 32'h0, 5'd7, 32'hABCD_0000 + i, 0, 0, rds[i]);
      checks++;
      if (wb_MemReadData !== wants[i]) $display("[TB] FAIL load_data[%0d]: got %h want %h", i, wb_MemReadData, wants[i]);
      else passes++;
      checks++;
      if (obs_stall_cycles != 2) $display("[TB] FAIL load_stall[%0d]: got %0d want 2", i, obs_stall_cycles);
      else passes++;
      checks++;
      if ({obs_req_seen, obs_we, obs_be, obs_addr} !== {1'b1, 1'b0, bes[i], 9'h040})
        $display("[TB] FAIL load_req[%0d]: got %h want %h", i, {obs_req_seen, obs_we, obs_be, obs_addr},
                 {1'b1, 1'b0, bes[i], 9'h040});
      else passes++;
    end
  endtask

  task automatic test_store_sb();
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h41, 32'h1234_56AB, 5'd0, 32'h00B0_80A3, 1, 1, 32'hFFFF_FFFF);
    checks++;
    if ({obs_req_seen, obs_we, obs_be} !== {1'b1, 1'b1, 4'b0010})
      $display("[TB] FAIL sb_we_be: got %b want 110010", {obs_req_seen, obs_we, obs_be});
    else passes++;
    checks++;
    if (obs_wdata !== 32'hABAB_ABAB) $display("[TB] FAIL sb_wdata: got %h want ababab ab", obs_wdata);
    else passes++;
    checks++;
    if (obs_addr !== 9'h010) $display("[TB] FAIL sb_addr: got %h want 010", obs_addr);
    else passes++;
    checks++;
    if ({wb_valid, wb_MemReadData} !== {1'b1, 32'h0}) $display("[TB] FAIL sb_wb: got %b/%h want 1/0", wb_valid, wb_MemReadData);
    else passes++;
    checks++;
    if (obs_stall_cycles != 4) $display("[TB] FAIL sb_stall: got %0d want 4", obs_stall_cycles);
    else passes++;
  endtask

  task automatic test_misalign();
    logic [2:0]  f3s[2]   = '{3'b010, 3'b011};
    logic [31:0] addrs[2] = '{32'h102, 32'h100};
    for (int i = 0; i < 2; i++) begin
      run_op(1'b1, 1'b0, 1'b1, 1'b1, f3s[i], addrs[i], 32'h0, 5'd9, 32'h0, 0, 0, 32'h0);
      checks++;
      if ({obs_misalign, obs_req_seen, obs_stall_cycles != 0} !== 3'b100)
        $display("[TB] FAIL misalign_flag[%0d]: got err/req/stall %b want 100", i,
                 {obs_misalign, obs_req_seen, obs_stall_cycles != 0});
      else passes++;
      checks++;
      if ({wb_valid, wb_RegWrite} !== 2'b10) $display("[TB] FAIL misalign_wb[%0d]: got %b want 10", i, {wb_valid, wb_RegWrite});
      else passes++;
      @(negedge clk);
      checks++;
      if (misalign_err !== 1'b0) $display("[TB] FAIL misalign_pulse[%0d]: got %b want 0", i, misalign_err);
      else passes++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_gnt_delay();
    logic [31:0] rd;
    rd = $urandom;
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h1F0, 32'h0, 5'd12, 32'h1111_2222, 3, 2, rd);
    checks++;
    if (obs_stall_cycles != 7) $display("[TB] FAIL gnt_delay_stall: got %0d want 7", obs_stall_cycles);
    else passes++;
    checks++;
    if ({obs_unstable, obs_bubble_bad} !== 2'b00) $display("[TB] FAIL gnt_delay_hold: unstable/bubble %b want 00", {obs_unstable, obs_bubble_bad});
    else passes++;
    checks++;
    if (wb_obs !== exp_wb(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h1F0, 5'd12, 32'h1111_2222, rd))
      $display("[TB] FAIL gnt_delay_wb: got %h want %h", wb_obs,
               exp_wb(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h1F0, 5'd12, 32'h1111_2222, rd));
    else passes++;
  endtask

  task automatic test_reset_in_wait();
    in_valid = 1'b1; in_MemRead = 1'b1; in_MemWrite = 1'b0; in_RegWrite = 1'b1;
    in_func3 = 3'b010; in_Alu_Result = 32'h80; in_rd = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; in_MemRead = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({mem_req, stall} !== 2'b00) $display("[TB] FAIL rst_wait_idle: req/stall got %b want 00", {mem_req, stall});
    else passes++;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    checks++;
    if ({wb_valid, stall} !== 2'b00) $display("[TB] FAIL rst_stale_rvalid: valid/stall got %b want 00", {wb_valid, stall});
    else passes++;
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h5A5A, 32'h0, 5'd4, 32'h0, 0, 0, 32'h0);
    checks++;
    if ({wb_valid, wb_Alu_Result} !== {1'b1, 32'h5A5A}) $display("[TB] FAIL rst_recover: got %b/%h want 1/00005a5a", wb_valid, wb_Alu_Result);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    rd = $urandom;
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h200, 32'h0, 5'd20, 32'h2, 0, 1, rd);
    checks++;
    if (wb_obs !== exp_wb(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h200, 5'd20, 32'h2, rd))
      $display("[TB] FAIL b2b_first_wb: got %h want %h", wb_obs,
               exp_wb(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h200, 5'd20, 32'h2, rd));
    else passes++;
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h206, 32'hCAFE_1234, 5'd0, 32'h3, 0, 0, 32'h0);
    checks++;
    if (obs_stall_cycles != 2) $display("[TB] FAIL b2b_second_stall: got %0d want 2", obs_stall_cycles);
    else passes++;
    checks++;
    if ({obs_we, obs_addr, obs_be, obs_wdata} !== {1'b1, 9'h081, 4'b1100, 32'h1234_1234})
      $display("[TB] FAIL b2b_second_req: got %h want %h", {obs_we, obs_addr, obs_be, obs_wdata},
               {1'b1, 9'h081, 4'b1100, 32'h1234_1234});
    else passes++;
  endtask

  task automatic test_random();
    logic [2:0]  f3opts[10] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010, 3'b011, 3'b110};
    logic        mr, mw, rw, m2r, legal, is_mem;
    logic [2:0]  f3;
    logic [31:0] a, d, instr, rdata;
    logic [4:0]  rd;
    int          kind, gd, rv, exp_stall;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      mr = (kind == 1); mw = (kind == 2);
      rw = 1'($urandom_range(0, 1)); m2r = 1'($urandom_range(0, 1));
      f3 = f3opts[$urandom_range(0, 9)];
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a - (a % 4);
      d = $urandom; instr = $urandom; rdata = $urandom; rd = 5'($urandom_range(0, 31));
      gd = $urandom_range(0, 3); rv = $urandom_range(0, 3);
      is_mem = mr || mw;
      legal = exp_legal(f3, a);
      exp_stall = (is_mem && legal) ? (2 + gd + rv) : 0;
      run_op(mr, mw, rw, m2r, f3, a, d, rd, instr, gd, rv, rdata);
      checks++;
      if (wb_obs !== exp_wb(mr, mw, rw, m2r, f3, a, rd, instr, rdata))
        $display("[TB] FAIL rand_wb[%0d]: got %h want %h", i, wb_obs, exp_wb(mr, mw, rw, m2r, f3, a, rd, instr, rdata));
      else passes++;
      checks++;
      if (obs_stall_cycles != exp_stall) $display("[TB] FAIL rand_stall[%0d]: got %0d want %0d", i, obs_stall_cycles, exp_stall);
      else passes++;
      checks++;
      if (obs_misalign !== (is_mem && !legal)) $display("[TB] FAIL rand_misalign[%0d]: got %b want %b", i, obs_misalign, is_mem && !legal);
      else passes++;
      if (is_mem && legal) begin
        checks++;
        if ({obs_req_seen, obs_we, obs_addr, obs_be} !== {1'b1, mw, AW'(a >> 2), exp_be(f3, a)})
          $display("[TB] FAIL rand_req[%0d]: got %h want %h", i, {obs_req_seen, obs_we, obs_addr, obs_be},
                   {1'b1, mw, AW'(a >> 2), exp_be(f3, a)});
        else passes++;
        checks++;
        if ({obs_unstable, obs_bubble_bad} !== 2'b00) $display("[TB] FAIL rand_hold[%0d]: unstable/bubble %b want 00", i, {obs_unstable, obs_bubble_bad});
        else passes++;
        if (mw) begin
          checks++;
          if (obs_wdata !== exp_wdata(f3, d)) $display("[TB] FAIL rand_wdata[%0d]: got %h want %h", i, obs_wdata, exp_wdata(f3, d));
          else passes++;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_RegWrite = 1'b0; in_MemtoReg = 1'b0; in_MemRead = 1'b0;
    in_MemWrite = 1'b0; in_Alu_Result = 32'h0; in_RD_Two = 32'h0; in_rd = 5'h0; in_func3 = 3'h0;
    in_Curr_Instr = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    $display("[TB] starting mem_stage_lsu bench");
    test_reset();
    test_alu_op();
    test_loads();
    test_store_sb();
    test_misalign();
    test_gnt_delay();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
